// File: rtl/scan_pkg.sv
// Shared encodings for the token scanner: FSM states, token-type codes and
// the ASCII ranges used to classify characters.
package scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_IDENT = 2'd1,
        ST_NUM   = 2'd2,
        ST_BAD   = 2'd3
    } scan_state_e;

    localparam logic [1:0] TOK_NONE = 2'd0;
    localparam logic [1:0] TOK_ID   = 2'd1;
    localparam logic [1:0] TOK_NUM  = 2'd2;
    localparam logic [1:0] TOK_ERR  = 2'd3;

    localparam logic [7:0] ASCII_UPPER_A    = 8'h41;
    localparam logic [7:0] ASCII_UPPER_Z    = 8'h5A;
    localparam logic [7:0] ASCII_LOWER_A    = 8'h61;
    localparam logic [7:0] ASCII_LOWER_Z    = 8'h7A;
    localparam logic [7:0] ASCII_DIGIT_0    = 8'h30;
    localparam logic [7:0] ASCII_DIGIT_9    = 8'h39;
    localparam logic [7:0] ASCII_UNDERSCORE = 8'h5F;

    // Token type reported when a token ends while the FSM sits in state s.
    function automatic logic [1:0] tok_of_state(input scan_state_e s);
        logic [1:0] t;
        case (s)
            ST_IDENT: t = TOK_ID;
            ST_NUM:   t = TOK_NUM;
            ST_BAD:   t = TOK_ERR;
            default:  t = TOK_NONE;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/char_class.sv
// Combinational character classifier: letter / digit / (implicit) delimiter.
// Any set bit above the low byte makes the character a delimiter.
module char_class
    import scan_pkg::*;
#(
    parameter int CHAR_W           = 8,
    parameter int ALLOW_UNDERSCORE = 1
) (
    input  logic [CHAR_W-1:0] i_char,
    output logic              o_is_letter,
    output logic              o_is_digit
);

    logic       w_wide;
    logic [7:0] w_lo;

    assign w_lo   = i_char[7:0];
    assign w_wide = ((i_char >> 8) != {CHAR_W{1'b0}});

    // Range decode of the low byte, suppressed for wide characters.
    always_comb begin
        o_is_letter = 1'b0;
        o_is_digit  = 1'b0;
        if (w_wide) begin
            o_is_letter = 1'b0;
            o_is_digit  = 1'b0;
        end else begin
            o_is_digit  = (w_lo >= ASCII_DIGIT_0) && (w_lo <= ASCII_DIGIT_9);
            o_is_letter = ((w_lo >= ASCII_UPPER_A) && (w_lo <= ASCII_UPPER_Z)) ||
                          ((w_lo >= ASCII_LOWER_A) && (w_lo <= ASCII_LOWER_Z)) ||
                          ((ALLOW_UNDERSCORE != 0) && (w_lo == ASCII_UNDERSCORE));
        end
    end

endmodule

// File: rtl/token_scan_fsm.sv
// Character-stream tokenizer: classifies runs of letters/digits into ID, NUM
// or ERR tokens and reports type and saturated length over valid/ready.
module token_scan_fsm
    import scan_pkg::*;
#(
    parameter int CHAR_W           = 8,
    parameter int LEN_W            = 8,
    parameter int MAX_LEN          = 32,
    parameter int ALLOW_UNDERSCORE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [CHAR_W-1:0] in_char,
    input  logic              in_last,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        out_type,
    output logic [LEN_W-1:0]  out_len,
    output logic              id_digit
);

    localparam logic [LEN_W-1:0] LP_MAX  = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LP_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] LP_ZERO = {LEN_W{1'b0}};

    scan_state_e      r_state;
    logic [LEN_W-1:0] r_len;
    logic             r_out_valid;
    logic [1:0]       r_out_type;
    logic [LEN_W-1:0] r_out_len;
    logic             r_id_digit;

    logic             w_letter;
    logic             w_digit;
    logic             w_alnum;
    logic             w_accept;
    logic             w_at_max;
    logic [LEN_W-1:0] w_grow_len;

    scan_state_e      w_nxt_state;
    logic [LEN_W-1:0] w_nxt_len;
    logic             w_nxt_id_digit;
    logic             w_report;
    logic [1:0]       w_rep_type;
    logic [LEN_W-1:0] w_rep_len;

    char_class #(
        .CHAR_W           (CHAR_W),
        .ALLOW_UNDERSCORE (ALLOW_UNDERSCORE)
    ) u_char_class (
        .i_char      (in_char),
        .o_is_letter (w_letter),
        .o_is_digit  (w_digit)
    );

    assign w_alnum    = w_letter || w_digit;
    assign in_ready   = !r_out_valid || out_ready;
    assign w_accept   = in_valid && in_ready;
    assign w_at_max   = (r_len == LP_MAX);
    assign w_grow_len = w_at_max ? r_len : (r_len + LP_ONE);

    // Next-state, length and report decision for one accepted character.
    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_len      = r_len;
        w_nxt_id_digit = r_id_digit;
        w_report       = 1'b0;
        w_rep_type     = TOK_NONE;
        w_rep_len      = r_len;
        if (w_accept) begin
            w_nxt_id_digit = 1'b0;
            if (w_alnum) begin
                case (r_state)
                    ST_IDLE: begin
                        w_nxt_state = w_letter ? ST_IDENT : ST_NUM;
                        w_nxt_len   = LP_ONE;
                    end
                    ST_IDENT: begin
                        w_nxt_state    = w_at_max ? ST_BAD : ST_IDENT;
                        w_nxt_len      = w_grow_len;
                        w_nxt_id_digit = w_digit && !in_last;
                    end
                    ST_NUM: begin
                        w_nxt_state = (w_at_max || w_letter) ? ST_BAD : ST_NUM;
                        w_nxt_len   = w_grow_len;
                    end
                    ST_BAD: begin
                        w_nxt_state = ST_BAD;
                        w_nxt_len   = w_grow_len;
                    end
                    default: begin
                        w_nxt_state = ST_IDLE;
                        w_nxt_len   = LP_ZERO;
                    end
                endcase
                // End of stream closes the token using the post-transition view.
                if (in_last) begin
                    w_report    = 1'b1;
                    w_rep_type  = tok_of_state(w_nxt_state);
                    w_rep_len   = w_nxt_len;
                    w_nxt_state = ST_IDLE;
                    w_nxt_len   = LP_ZERO;
                end else begin
                    w_report    = 1'b0;
                end
            end else begin
                w_report    = (r_state != ST_IDLE);
                w_rep_type  = tok_of_state(r_state);
                w_rep_len   = r_len;
                w_nxt_state = ST_IDLE;
                w_nxt_len   = LP_ZERO;
            end
        end else begin
            w_report = 1'b0;
        end
    end

    // State, length, legacy flag and report register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_len       <= LP_ZERO;
            r_id_digit  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_type  <= TOK_NONE;
            r_out_len   <= LP_ZERO;
        end else begin
            r_state    <= w_nxt_state;
            r_len      <= w_nxt_len;
            r_id_digit <= w_nxt_id_digit;
            if (w_report) begin
                r_out_valid <= 1'b1;
                r_out_type  <= w_rep_type;
                r_out_len   <= w_rep_len;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end else begin
                r_out_valid <= r_out_valid;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_type  = r_out_type;
    assign out_len   = r_out_len;
    assign id_digit  = r_id_digit;

endmodule

// File: tb/tb_token_scan_fsm.sv
// Bench for token_scan_fsm: directed scenarios plus a randomized stream
// checked against a token-level reference model.
module tb_token_scan_fsm;

    localparam int CW = 8;
    localparam int LW = 8;
    localparam int ML = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [CW-1:0] in_char = '0;
    logic          in_last = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [1:0]    out_type;
    logic [LW-1:0] out_len;
    logic          id_digit;

    int errors = 0;
    int checks = 0;

    logic [9:0] exp_q[$];
    logic [9:0] got_q[$];
    logic [7:0] tok_q[$];
    logic       exp_id = 1'b0;
    bit         rand_ready = 1'b0;

    always #5 clk = ~clk;

    token_scan_fsm #(
        .CHAR_W(CW), .LEN_W(LW), .MAX_LEN(ML), .ALLOW_UNDERSCORE(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_char(in_char),
        .in_last(in_last), .in_ready(in_ready), .out_valid(out_valid),
        .out_ready(out_ready), .out_type(out_type), .out_len(out_len),
        .id_digit(id_digit)
    );

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) got_q.push_back({out_type, out_len});
    end

    function automatic bit m_letter(input logic [7:0] c);
        return (c >= 8'h41 && c <= 8'h5A) || (c >= 8'h61 && c <= 8'h7A) || (c == 8'h5F);
    endfunction

    function automatic bit m_digit(input logic [7:0] c);
        return (c >= 8'h30 && c <= 8'h39);
    endfunction

    // A token is a maximal run of letters/digits; its class follows from its content.
    function automatic void m_finalize();
        int n;
        bit all_dig;
        logic [1:0] t;
        logic [7:0] l;
        n = tok_q.size();
        all_dig = 1'b1;
        foreach (tok_q[i]) if (!m_digit(tok_q[i])) all_dig = 1'b0;
        if (n > ML)                 t = 2'd3;
        else if (m_letter(tok_q[0])) t = 2'd1;
        else if (all_dig)           t = 2'd2;
        else                        t = 2'd3;
        l = (n > ML) ? 8'(ML) : 8'(n);
        exp_q.push_back({t, l});
        tok_q.delete();
    endfunction

    function automatic void m_accept(input logic [7:0] c, input bit last);
        bit in_ident;
        if (m_letter(c) || m_digit(c)) begin
            in_ident = (tok_q.size() >= 1) && (tok_q.size() <= ML) && m_letter(tok_q[0]);
            exp_id = in_ident && m_digit(c) && !last;
            tok_q.push_back(c);
            if (last) m_finalize();
        end else begin
            exp_id = 1'b0;
            if (tok_q.size() > 0) m_finalize();
        end
    endfunction

    // Offer one character; returns just after the accepting edge.
    task automatic send(input logic [7:0] c, input bit last);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_char  = c;
        in_last  = last;
        for (int k = 0; k < 200 && !ok; k++) begin
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (ok) begin
            m_accept(c, last);
        end else begin
            errors++;
            checks++;
            $display("FAIL send_timeout: char %02h never accepted", c);
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i], 1'b0);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", out_valid); end
        checks++; if (out_type !== 2'd0) begin errors++; $display("FAIL reset_type: got %0d expected 0", out_type); end
        checks++; if (out_len !== 8'd0) begin errors++; $display("FAIL reset_len: got %0d expected 0", out_len); end
        checks++; if (id_digit !== 1'b0) begin errors++; $display("FAIL reset_id_digit: got %0b expected 0", id_digit); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_ident();
        got_q.delete(); exp_q.delete();
        out_ready = 1'b1;
        send("a", 1'b0);
        send("b", 1'b0);
        checks++; if (id_digit !== 1'b0) begin errors++; $display("FAIL ident_id_after_b: got %0b expected 0", id_digit); end
        send("1", 1'b0);
        checks++; if (id_digit !== 1'b1) begin errors++; $display("FAIL ident_id_after_1: got %0b expected 1", id_digit); end
        send(" ", 1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ident_valid: got %0b expected 1", out_valid); end
        checks++; if (out_type !== 2'd1 || out_len !== 8'd3) begin errors++; $display("FAIL ident_report: got %0d/%0d expected 1/3", out_type, out_len); end
        checks++; if (id_digit !== 1'b0) begin errors++; $display("FAIL ident_id_cleared: got %0b expected 0", id_digit); end
        drain();
        checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL ident_count: got %0d expected 1", got_q.size()); end
        else if (got_q[0] !== {2'd1, 8'd3}) begin errors++; $display("FAIL ident_popped: got %03h expected %03h", got_q[0], {2'd1, 8'd3}); end
    endtask

    task automatic test_num_err();
        got_q.delete(); exp_q.delete();
        send_str("123;");
        drain();
        checks++; if (got_q.size() !== 1 || got_q[0] !== {2'd2, 8'd3}) begin errors++; $display("FAIL num_report: got n=%0d first=%03h expected n=1 %03h", got_q.size(), got_q.size() > 0 ? got_q[0] : 10'h0, {2'd2, 8'd3}); end
        got_q.delete();
        send_str("12ab ");
        drain();
        checks++; if (got_q.size() !== 1 || got_q[0] !== {2'd3, 8'd4}) begin errors++; $display("FAIL err_report: got n=%0d first=%03h expected n=1 %03h", got_q.size(), got_q.size() > 0 ? got_q[0] : 10'h0, {2'd3, 8'd4}); end
    endtask

    task automatic test_overflow();
        got_q.delete(); exp_q.delete();
        send_str("abcdef ");
        drain();
        checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL overflow_count: got %0d expected 1", got_q.size()); end
        else if (got_q[0] !== {2'd3, 8'd4}) begin errors++; $display("FAIL overflow_report: got %03h expected %03h", got_q[0], {2'd3, 8'd4}); end
    endtask

    task automatic test_backpressure();
        got_q.delete(); exp_q.delete();
        out_ready = 1'b0;
        send("a", 1'b0);
        send(" ", 1'b0);
        in_valid = 1'b1;
        in_char  = "b";
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc%0d: got %0b expected 0", k, in_ready); end
            checks++; if (out_valid !== 1'b1 || out_type !== 2'd1 || out_len !== 8'd1) begin errors++; $display("FAIL bp_hold cyc%0d: got v%0b %0d/%0d expected v1 1/1", k, out_valid, out_type, out_len); end
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        send_str("b c ");
        drain();
        checks++; if (got_q.size() !== 3) begin errors++; $display("FAIL bp_count: got %0d expected 3", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 3; i++) begin
            checks++; if (got_q[i] !== {2'd1, 8'd1}) begin errors++; $display("FAIL bp_report%0d: got %03h expected %03h", i, got_q[i], {2'd1, 8'd1}); end
        end
    endtask

    task automatic test_last();
        got_q.delete(); exp_q.delete();
        send("x", 1'b0);
        send("y", 1'b0);
        send("z", 1'b1);
        checks++; if (out_valid !== 1'b1 || out_type !== 2'd1 || out_len !== 8'd3) begin errors++; $display("FAIL last_report: got v%0b %0d/%0d expected v1 1/3", out_valid, out_type, out_len); end
        send_str("  ;");
        drain();
        checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL last_count: got %0d expected 1", got_q.size()); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL last_idle_valid: got %0b expected 0", out_valid); end
    endtask

    task automatic test_async_reset();
        got_q.delete(); exp_q.delete();
        out_ready = 1'b0;
        send("a", 1'b0);
        send("1", 1'b0);
        checks++; if (id_digit !== 1'b1) begin errors++; $display("FAIL ar_pre_id: got %0b expected 1", id_digit); end
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++; if (id_digit !== 1'b0) begin errors++; $display("FAIL ar_id_digit: got %0b expected 0", id_digit); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        tok_q.delete(); exp_id = 1'b0;
        send("p", 1'b0);
        send(" ", 1'b0);
        checks++; if (out_valid !== 1'b1 || out_len !== 8'd1) begin errors++; $display("FAIL ar_discard: got v%0b len %0d expected v1 len 1", out_valid, out_len); end
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_type !== 2'd0 || out_len !== 8'd0) begin errors++; $display("FAIL ar_outputs: got v%0b %0d/%0d expected v0 0/0", out_valid, out_type, out_len); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        got_q.delete();
        send_str("x ");
        drain();
        checks++; if (got_q.size() !== 1 || got_q[0] !== {2'd1, 8'd1}) begin errors++; $display("FAIL ar_after: got n=%0d first=%03h expected n=1 %03h", got_q.size(), got_q.size() > 0 ? got_q[0] : 10'h0, {2'd1, 8'd1}); end
    endtask

    task automatic test_random();
        logic [7:0] c;
        bit last;
        int r;
        int id_errs;
        got_q.delete(); exp_q.delete(); tok_q.delete();
        exp_id = 1'b0;
        id_errs = 0;
        rand_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1:    c = 8'($urandom_range(8'h61, 8'h7A));
                2, 3:    c = 8'($urandom_range(8'h41, 8'h5A));
                4, 5, 6: c = 8'($urandom_range(8'h30, 8'h39));
                7:       c = 8'h5F;
                8:       c = 8'h20;
                default: c = 8'($urandom_range(0, 255));
            endcase
            last = ($urandom_range(0, 15) == 0);
            send(c, last);
            checks++;
            if (id_digit !== exp_id) begin
                errors++;
                if (id_errs < 5) $display("FAIL rand_id_digit step%0d: got %0b expected %0b", i, id_digit, exp_id);
                id_errs++;
            end
        end
        send(8'h20, 1'b0);
        rand_ready = 1'b0;
        drain();
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_report%0d: got %03h expected %03h", i, got_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_ident();
        test_num_err();
        test_overflow();
        test_backpressure();
        test_last();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/token_scan_fsm.md
Name: token_scan_fsm

Overview:
- Parametrised successor to the single-bit identifier-detect FSM; scans a character stream and classifies it into tokens.
- Token classes: identifier, number, error. Each completed token is reported once with its type and length, over a valid/ready output register.
- Keeps the legacy level flag `id_digit`: asserted while inside an identifier whose last character was a digit.
- Sits between the character source (UART/ROM feeder) and the downstream parser.

Parameters:
- CHAR_W, 8: character width; any set bit above [7:0] classifies the character as a delimiter.
- LEN_W, 8: width of the length counter and `out_len`.
- MAX_LEN, 32: maximum legal token length, 1..2^LEN_W-1.
- ALLOW_UNDERSCORE, 1: when 1, '_' (0x5F) is classed as a letter; when 0, as a delimiter.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  `in_char` is valid.
- in_char  in  CHAR_W  character.
- in_last  in  1  end of stream; the token ends after this character.
- in_ready  out  1  character accepted this cycle when `in_valid` && `in_ready`.
- out_valid  out  1  token report pending.
- out_ready  in  1  consumer takes the report.
- out_type  out  2  1 = ID, 2 = NUM, 3 = ERR (0 only out of reset).
- out_len  out  LEN_W  token length, saturated at MAX_LEN.
- id_digit  out  1  legacy flag, registered.

Behaviour:
- Reset: clk and asynchronous active-low rst_n. While rst_n = 0: state = IDLE, len = 0, `out_valid` = 0, `out_type` = 0, `out_len` = 0, `id_digit` = 0. A partial token in progress at reset is discarded.
- Character classes: letter = A-Z, a-z (plus '_' if enabled); digit = 0-9; delimiter = everything else.
- `in_ready` = !`out_valid` || `out_ready` (combinational). Nothing changes in a cycle with no accepted character, except that `out_valid` clears on `out_ready`.
- State transitions on an accepted character:
  - IDLE: letter -> IDENT, len = 1. Digit -> NUM, len = 1. Delimiter -> stay IDLE, no report.
  - IDENT: letter/digit -> IDENT, len + 1. Delimiter -> report ID, go IDLE.
  - NUM: digit -> NUM, len + 1. Letter -> BAD, len + 1. Delimiter -> report NUM, go IDLE.
  - BAD: letter/digit -> BAD, len + 1 (saturating). Delimiter -> report ERR, go IDLE.
- Overflow: a letter/digit arriving while len == MAX_LEN -> BAD, len held at MAX_LEN.
- `in_last` on an accepted letter/digit: apply the transition, then report immediately using the resulting state and len, and go IDLE.
- `in_last` on a delimiter: behaves as a plain delimiter.
- Report timing: `out_valid` rises the cycle after the terminating character is accepted. `out_type`/`out_len` are registered and held stable while `out_valid` && !`out_ready`.
- Simultaneous pop and new report (`out_ready` high in the same cycle a terminator is accepted): the new report replaces the old; `out_valid` stays 1.
- `id_digit`: set the cycle after a digit is accepted in IDENT. Cleared the cycle after any other accepted character, or on a report from IDENT. Holds its value across cycles with no accepted character.
- No combinational path from `in_char` to any output.

Decomposition:
- Package `scan_pkg` holds:
  - state encoding (IDLE/IDENT/NUM/BAD);
  - token-type codes TOK_ID = 1, TOK_NUM = 2, TOK_ERR = 3;
  - ASCII range constants for letter/digit/underscore.
- Sub-module `char_class`: combinational, CHAR_W-parametrised classifier returning {is_letter, is_digit}; instantiated once.
- FSM, length counter and output register live in the top module.

Test Plan:
- "ab1 " streamed, `out_ready` = 1 -> `id_digit` = 1 the cycle after '1'; one report ID, len 3, the cycle after ' '; `id_digit` back to 0.
- "123;" -> one report NUM, len 3. Then "12ab " -> one report ERR, len 4.
- MAX_LEN = 4, "abcdef " -> exactly one report ERR, len 4; no intermediate reports.
- "a b c " with `out_ready` held 0 -> first report ID/1 held stable; `in_ready` = 0 from the next cycle; release `out_ready` -> reports ID/1, ID/1, ID/1 in order, none lost.
- "xyz" with `in_last` on 'z', no delimiter -> report ID, len 3 the next cycle. Leading delimiters "  ;" -> no report.
- rst_n pulsed low mid-"abc" (between clock edges) -> all outputs 0 immediately; then "x " -> single report ID, len 1.
